matrix_mem_port: RTL and testbench
==================================

// Module: matrix_mem_port
// PURPOSE
//  Word-addressed scratch memory that services the multiplier's load/store
//  handshake (start_memory_transaction / done_memory_transaction) and a host
//  port used to preload A/B operands and read back C. One transaction in flight
//  at a time; fixed, parameterised completion latency; round-robin arbitration.
// PARAMETERS
//  DEPTH   64  number of 32-bit words (byte space 0 .. 4*DEPTH-1)
//  LAT     2   cycles from request acceptance to done pulse (LAT >= 1)
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, synchronous, active-high
//  acc_req       in   1   accelerator request (start_memory_transaction)
//  acc_we        in   1   1 = store, 0 = load
//  acc_addr      in   32  byte address
//  acc_wdata     in   32  store data
//  acc_rdata     out  32  load data
//  acc_done      out  1   1-cycle completion pulse (done_memory_transaction)
//  host_req      in   1   host request
//  host_we       in   1   1 = write, 0 = read
//  host_addr     in   32  byte address
//  host_wdata    in   32  write data
//  host_rdata    out  32  read data
//  host_done     out  1   1-cycle completion pulse
//  err           out  1   1-cycle pulse with done on bad address
//  err_count     out  8   saturating count of bad-address transactions
// BEHAVIOUR
//  - Reset: state IDLE, acc_done=host_done=err=0, acc_rdata=host_rdata=0,
//    err_count=0, last_grant=HOST. Memory array is not cleared.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: if any req, accept: latch port id, we, addr, wdata; cnt<=LAT-1;
//    go BUSY. Requests are sampled only in IDLE; other cycles ignored.
//    BUSY: cnt decrements; at cnt==0 perform access, go DONE.
//    DONE: granted port's done=1 (and err if bad) for exactly this cycle; ->IDLE.
//  - Latency: accept at edge T -> done high in cycle after edge T+LAT.
//    Back-to-back: req held high through DONE is re-accepted in next IDLE,
//    so min spacing between done pulses is LAT+2 cycles.
//  - Arbitration: only one req -> grant it. Both -> grant port != last_grant;
//    last_grant updated on every acceptance. First tie after reset goes to ACC.
//  - Address: word index = addr[31:2]. Bad if addr[1:0]!=0 or index>=DEPTH.
//    Bad write: dropped. Bad read: rdata <= 0. err pulses with done;
//    err_count increments, saturates at 255.
//  - Write commits at the BUSY->DONE edge; read data registered at the same
//    edge into the granted port's rdata, held until that port's next read
//    completes. Writes do not disturb either rdata.
//  - The non-granted port's done and rdata are untouched.
//  - Reset mid-transaction: abandon, no write commit, no done pulse.
// TESTING
//  1. Host writes 0x0000_0005 @0x10, then reads @0x10 -> host_done 1 cycle
//     at LAT+1 after accept, host_rdata=0x5; acc_done stays 0.
//  2. acc_req+host_req both high in IDLE after reset -> ACC served first,
//     HOST next; then tie again -> ACC (alternation).
//  3. Host preloads 18 words @0x00..0x44; acc reads 18 words sequentially
//     -> acc_rdata matches each, 18 acc_done pulses, spacing LAT+2.
//  4. acc write @0x102 (misaligned) and read @4*DEPTH -> err with done,
//     memory unchanged, rdata=0, err_count=2; 300 bad ops -> err_count=255.
//  5. rst asserted during BUSY of write 0xDEAD @0x08 -> no done, word @0x08
//     keeps prior value, outputs at reset values next cycle.
//  6. LAT=1 build: accept at T -> done in cycle after edge T+1; read-after-write same address returns new data.

Source files
------------

// File: rtl/matrix_mem_port.sv
// rtl/matrix_mem_port.sv - word-addressed scratch memory shared by the multiplier and a host port
// One transaction in flight; fixed LAT-cycle completion; round-robin arbitration on ties.
module matrix_mem_port #(
   parameter int DEPTH = 64,
   parameter int LAT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        acc_req,
   input  logic        acc_we,
   input  logic [31:0] acc_addr,
   input  logic [31:0] acc_wdata,
   output logic [31:0] acc_rdata,
   output logic        acc_done,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [31:0] host_addr,
   input  logic [31:0] host_wdata,
   output logic [31:0] host_rdata,
   output logic        host_done,
   output logic        err,
   output logic [7:0]  err_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic P_ACC  = 1'b0;
   localparam logic P_HOST = 1'b1;

   logic [31:0]   mem [DEPTH];

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          port_q, port_d;
   logic          last_q, last_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          bad_q, bad_d;
   logic [31:0]   acc_rdata_q, acc_rdata_d;
   logic [31:0]   host_rdata_q, host_rdata_d;
   logic [7:0]    err_count_q, err_count_d;

   logic          grant_host;
   logic          addr_bad;
   logic          commit;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word;

   // On a tie the port that did not win last time is served.
   assign grant_host = host_req && (!acc_req || (last_q == P_ACC));
   assign idx        = addr_q[AW+1:2];
   assign addr_bad   = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
   assign commit     = (state_q == S_BUSY) && (cnt_q == '0);
   assign rd_word    = addr_bad ? 32'd0 : mem[idx];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      port_d       = port_q;
      last_d       = last_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      bad_d        = bad_q;
      acc_rdata_d  = acc_rdata_q;
      host_rdata_d = host_rdata_q;
      err_count_d  = err_count_q;
      case (state_q)
         S_IDLE: begin
            if (acc_req || host_req) begin
               port_d  = grant_host;
               last_d  = grant_host;
               we_d    = grant_host ? host_we    : acc_we;
               addr_d  = grant_host ? host_addr  : acc_addr;
               wdata_d = grant_host ? host_wdata : acc_wdata;
               cnt_d   = CW'(LAT - 1);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
               bad_d   = addr_bad;
               if (!we_q) begin
                  if (port_q == P_HOST) host_rdata_d = rd_word;
                  else                  acc_rdata_d  = rd_word;
               end
               if (addr_bad && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         port_q       <= P_ACC;
         last_q       <= P_HOST;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         bad_q        <= 1'b0;
         acc_rdata_q  <= 32'd0;
         host_rdata_q <= 32'd0;
         err_count_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         port_q       <= port_d;
         last_q       <= last_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         bad_q        <= bad_d;
         acc_rdata_q  <= acc_rdata_d;
         host_rdata_q <= host_rdata_d;
         err_count_q  <= err_count_d;
      end
   end

   // Storage is deliberately not reset; a reset during BUSY suppresses the commit.
   always_ff @(posedge clk) begin
      if (!rst && commit && we_q && !addr_bad) mem[idx] <= wdata_q;
   end

   assign acc_done   = (state_q == S_DONE) && (port_q == P_ACC);
   assign host_done  = (state_q == S_DONE) && (port_q == P_HOST);
   assign err        = (state_q == S_DONE) && bad_q;
   assign acc_rdata  = acc_rdata_q;
   assign host_rdata = host_rdata_q;
   assign err_count  = err_count_q;
endmodule

// File: tb/tb_matrix_mem_port.sv
// tb/tb_matrix_mem_port.sv - bench for matrix_mem_port, LAT=2 and LAT=1 builds on shared stimulus
// A transaction-level model predicts done/err/rdata/err_count for both builds every cycle.
module tb_matrix_mem_port;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        acc_req = 1'b0, acc_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
   logic [31:0] acc_addr = '0, acc_wdata = '0, host_addr = '0, host_wdata = '0;
   logic [31:0] acc_rdata_w [2];
   logic [31:0] host_rdata_w [2];
   logic        acc_done_w [2];
   logic        host_done_w [2];
   logic        err_w [2];
   logic [7:0]  err_count_w [2];

   matrix_mem_port #(.DEPTH(DEPTH), .LAT(2)) u_dut_lat2 (
      .clk(clk), .rst(rst),
      .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
      .acc_rdata(acc_rdata_w[0]), .acc_done(acc_done_w[0]),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata_w[0]), .host_done(host_done_w[0]),
      .err(err_w[0]), .err_count(err_count_w[0]));

   matrix_mem_port #(.DEPTH(DEPTH), .LAT(1)) u_dut_lat1 (
      .clk(clk), .rst(rst),
      .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
      .acc_rdata(acc_rdata_w[1]), .acc_done(acc_done_w[1]),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata_w[1]), .host_done(host_done_w[1]),
      .err(err_w[1]), .err_count(err_count_w[1]));

   int nchk = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   int          lat_of [2] = '{2, 1};
   logic [31:0] mmem [2][DEPTH];
   bit          mknown [2][DEPTH];
   longint      edge_n = 0;
   bit          m_init [2];
   bit          p_v [2];
   longint      p_at [2];
   bit          p_host [2], p_we [2];
   logic [31:0] p_addr [2], p_wd [2];
   bit          m_last [2];
   longint      m_free [2];
   bit          e_adone [2], e_hdone [2], e_err [2];
   logic [31:0] e_ard [2], e_hrd [2];
   bit          e_ardk [2], e_hrdk [2];
   int          e_cnt [2];

   // Transaction model: accepted at edge e, completes at edge e+LAT, port free again at e+LAT+2.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin : g_model
         bit bad, g, kn;
         logic [31:0] v;
         int w;
         e_adone[i] = 1'b0; e_hdone[i] = 1'b0; e_err[i] = 1'b0;
         if (rst) begin
            m_init[i] = 1'b1; p_v[i] = 1'b0; m_free[i] = edge_n + 1; m_last[i] = 1'b1;
            e_ard[i] = '0; e_hrd[i] = '0; e_ardk[i] = 1'b1; e_hrdk[i] = 1'b1; e_cnt[i] = 0;
         end else begin
            if (p_v[i] && p_at[i] == edge_n) begin
               w   = int'(p_addr[i][31:2]);
               bad = (p_addr[i][1:0] != 2'b00) || (w >= DEPTH);
               if (bad) begin
                  e_err[i] = 1'b1;
                  if (e_cnt[i] < 255) e_cnt[i]++;
               end
               if (p_we[i]) begin
                  if (!bad) begin mmem[i][w] = p_wd[i]; mknown[i][w] = 1'b1; end
               end else begin
                  v  = bad ? 32'd0 : mmem[i][w];
                  kn = bad ? 1'b1 : mknown[i][w];
                  if (p_host[i]) begin e_hrd[i] = v; e_hrdk[i] = kn; end
                  else begin e_ard[i] = v; e_ardk[i] = kn; end
               end
               if (p_host[i]) e_hdone[i] = 1'b1; else e_adone[i] = 1'b1;
               p_v[i] = 1'b0;
            end
            if (!p_v[i] && edge_n >= m_free[i] && (acc_req || host_req)) begin
               if (acc_req && host_req) g = !m_last[i];
               else g = host_req;
               m_last[i] = g; p_host[i] = g; p_v[i] = 1'b1;
               p_we[i]   = g ? host_we : acc_we;
               p_addr[i] = g ? host_addr : acc_addr;
               p_wd[i]   = g ? host_wdata : acc_wdata;
               p_at[i]   = edge_n + lat_of[i];
               m_free[i] = edge_n + lat_of[i] + 2;
            end
         end
      end
      edge_n++;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (m_init[i]) begin
            chk($sformatf("acc_done_lat%0d", lat_of[i]), 32'(acc_done_w[i]), 32'(e_adone[i]));
            chk($sformatf("host_done_lat%0d", lat_of[i]), 32'(host_done_w[i]), 32'(e_hdone[i]));
            chk($sformatf("err_lat%0d", lat_of[i]), 32'(err_w[i]), 32'(e_err[i]));
            chk($sformatf("err_count_lat%0d", lat_of[i]), 32'(err_count_w[i]), 32'(e_cnt[i]));
            if (e_ardk[i]) chk($sformatf("acc_rdata_lat%0d", lat_of[i]), acc_rdata_w[i], e_ard[i]);
            if (e_hrdk[i]) chk($sformatf("host_rdata_lat%0d", lat_of[i]), host_rdata_w[i], e_hrd[i]);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; acc_req = 1'b0; host_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Issue one request, hold it until the LAT=2 build signals done; k/k1 are negedges to done.
   task automatic op(input bit host, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output bit e, output int k, output int k1);
      bit got;
      @(negedge clk);
      if (host) begin host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd; end
      else begin acc_req = 1'b1; acc_we = we; acc_addr = addr; acc_wdata = wd; end
      k = 0; k1 = 0; got = 1'b0;
      while (!got && k < 40) begin
         @(negedge clk);
         k++;
         if (k1 == 0 && (host ? host_done_w[1] : acc_done_w[1])) k1 = k;
         got = host ? host_done_w[0] : acc_done_w[0];
      end
      if (!got) chk("op_timeout", 32'd0, 32'd1);
      rd = host ? host_rdata_w[0] : acc_rdata_w[0];
      e  = err_w[0];
      acc_req = 1'b0; host_req = 1'b0;
   endtask

   task automatic tie(output int first, output int second);
      bit got;
      int n;
      @(negedge clk);
      acc_req = 1'b1; acc_we = 1'b0; acc_addr = 32'h10;
      host_req = 1'b1; host_we = 1'b0; host_addr = 32'h10;
      first = -1; second = -1; n = 0;
      while (first < 0 && n < 40) begin
         @(negedge clk); n++;
         if (acc_done_w[0]) begin first = 0; acc_req = 1'b0; end
         else if (host_done_w[0]) begin first = 1; host_req = 1'b0; end
      end
      got = 1'b0;
      while (!got && n < 80) begin
         @(negedge clk); n++;
         if (acc_done_w[0]) begin second = 0; got = 1'b1; end
         else if (host_done_w[0]) begin second = 1; got = 1'b1; end
      end
      acc_req = 1'b0; host_req = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      return a;
   endfunction

   logic [31:0] rd;
   bit          e;
   int          k, k1, f, s;
   logic [31:0] exp3 [18];

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;

      op(1, 1, 32'h10, 32'h5, rd, e, k, k1);
      op(1, 0, 32'h10, 32'h0, rd, e, k, k1);
      chk("t1_host_rdata", rd, 32'h5);
      chk("t1_latency", 32'(k), 32'd3);
      chk("t1_err", 32'(e), 32'd0);
      chk("t6_lat1_latency", 32'(k1), 32'd2);
      chk("t6_lat1_raw", host_rdata_w[1], 32'h5);

      do_reset();
      tie(f, s);
      chk("t2_first_acc", 32'(f), 32'd0);
      chk("t2_second_host", 32'(s), 32'd1);
      tie(f, s);
      chk("t2_third_acc", 32'(f), 32'd0);

      for (int i = 0; i < 18; i++) begin
         exp3[i] = $urandom;
         op(1, 1, 32'(4 * i), exp3[i], rd, e, k, k1);
      end
      begin
         int n, cyc, last_cyc;
         n = 0; cyc = 0; last_cyc = 0;
         @(negedge clk);
         acc_req = 1'b1; acc_we = 1'b0; acc_addr = 32'h0;
         while (n < 18 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (acc_done_w[0]) begin
               chk($sformatf("t3_rdata_%0d", n), acc_rdata_w[0], exp3[n]);
               if (n > 0) chk($sformatf("t3_spacing_%0d", n), 32'(cyc - last_cyc), 32'd4);
               last_cyc = cyc; n++;
               acc_addr = 32'(4 * n);
            end
         end
         acc_req = 1'b0;
         chk("t3_done_pulses", 32'(n), 32'd18);
      end

      do_reset();
      op(0, 1, 32'h102, 32'h1234_5678, rd, e, k, k1);
      chk("t4_bad_write_err", 32'(e), 32'd1);
      op(0, 0, 32'(4 * DEPTH), 32'h0, rd, e, k, k1);
      chk("t4_bad_read_err", 32'(e), 32'd1);
      chk("t4_bad_read_rdata", rd, 32'h0);
      chk("t4_err_count_2", 32'(err_count_w[0]), 32'd2);
      op(0, 0, 32'h0, 32'h0, rd, e, k, k1);
      chk("t4_mem_unchanged", rd, exp3[0]);
      for (int i = 0; i < 299; i++) op(i[0], i[1], 32'h101 + 32'(i), 32'hBAD0, rd, e, k, k1);
      chk("t4_err_count_sat", 32'(err_count_w[0]), 32'd255);

      op(1, 1, 32'h08, 32'h1111, rd, e, k, k1);
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 32'h08; host_wdata = 32'hDEAD;
      @(negedge clk);
      rst = 1'b1; host_req = 1'b0;
      @(negedge clk);
      chk("t5_host_done", 32'(host_done_w[0]), 32'd0);
      chk("t5_err_count", 32'(err_count_w[0]), 32'd0);
      chk("t5_acc_rdata", acc_rdata_w[0], 32'h0);
      rst = 1'b0;
      op(1, 0, 32'h08, 32'h0, rd, e, k, k1);
      chk("t5_word_kept", rd, 32'h1111);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst        = ($urandom_range(0, 299) == 0);
         acc_req    = ($urandom_range(0, 2) != 0);
         acc_we     = $urandom_range(0, 1) == 1;
         acc_addr   = rnd_addr();
         acc_wdata  = $urandom;
         host_req   = ($urandom_range(0, 2) != 0);
         host_we    = $urandom_range(0, 1) == 1;
         host_addr  = rnd_addr();
         host_wdata = $urandom;
      end
      @(negedge clk);
      rst = 1'b0; acc_req = 1'b0; host_req = 1'b0;
      repeat (8) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
